// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-sequencing controller for the picoMIPS core.
// Runs one instruction at a time (fetch, execute, optional multiply wait)
// and drives the PC, instruction-register, register-file and multiplier
// strobes. Supports free-run, single-step, halt and a multiply-timeout fault.
//
// Handshake: mul_start is a one-cycle request; the multiplier answers with a
// one-cycle mul_done pulse, which is only honoured while in MUL_WAIT. There is
// no backpressure on any control output: each is a single-cycle strobe.
module pc_sequencer #(
   parameter int program_code_size = 8,
   parameter int mul_timeout       = 16,
   parameter int count_width       = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   input  logic                         step,
   input  logic [2:0]                   instr_class,
   input  logic                         branch_cond,
   input  logic [program_code_size-1:0] branch_target,
   input  logic                         mul_done,
   output logic                         pc_inc,
   output logic                         pc_load,
   output logic [program_code_size-1:0] pc_target,
   output logic                         ir_load,
   output logic                         reg_we,
   output logic                         mul_start,
   output logic                         halted,
   output logic                         fault,
   output logic [count_width-1:0]       retired,
   output logic [2:0]                   state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_EXEC     = 3'd2,
      S_MUL_WAIT = 3'd3,
      S_HALT     = 3'd4,
      S_FAULT    = 3'd5
   } state_t;

   localparam logic [2:0] CLASS_ALU     = 3'd0;
   localparam logic [2:0] CLASS_LOADIMM = 3'd1;
   localparam logic [2:0] CLASS_BRANCH  = 3'd2;
   localparam logic [2:0] CLASS_MUL     = 3'd3;
   localparam logic [2:0] CLASS_HALT    = 3'd4;

   // Last MUL_WAIT cycle before giving up on the multiplier.
   localparam logic [7:0] TIMEOUT_LAST = 8'(mul_timeout - 1);

   state_t                 state;
   state_t                 next_state;
   logic                   step_latch;
   logic [7:0]             timer;
   logic                   retire;       // instruction completes, pick next state
   logic                   count_retire; // bump the retired counter
   logic                   step_set;
   logic                   timer_clear;

   assign state_dbg = state;

   // Next-state and strobe decode; everything is forced quiet while reset is high.
   always_comb begin
      next_state   = state;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      pc_target    = '0;
      ir_load      = 1'b0;
      reg_we       = 1'b0;
      mul_start    = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
      retire       = 1'b0;
      count_retire = 1'b0;
      step_set     = 1'b0;
      timer_clear  = 1'b0;
      if (!reset) begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  next_state = S_FETCH;
               end else if (step) begin
                  step_set   = 1'b1;
                  next_state = S_FETCH;
               end
            end
            S_FETCH: begin
               ir_load    = 1'b1;
               next_state = S_EXEC;
            end
            S_EXEC: begin
               case (instr_class)
                  CLASS_ALU, CLASS_LOADIMM: begin
                     reg_we = 1'b1;
                     pc_inc = 1'b1;
                     retire = 1'b1;
                  end
                  CLASS_BRANCH: begin
                     if (branch_cond) begin
                        pc_load   = 1'b1;
                        pc_target = branch_target;
                     end else begin
                        pc_inc = 1'b1;
                     end
                     retire = 1'b1;
                  end
                  CLASS_MUL: begin
                     mul_start   = 1'b1;
                     timer_clear = 1'b1;
                     next_state  = S_MUL_WAIT;
                  end
                  CLASS_HALT: begin
                     count_retire = 1'b1;
                     next_state   = S_HALT;
                  end
                  default: begin
                     pc_inc = 1'b1;
                     retire = 1'b1;
                  end
               endcase
            end
            S_MUL_WAIT: begin
               // A done pulse on the final timeout cycle still completes the multiply.
               if (mul_done) begin
                  reg_we = 1'b1;
                  pc_inc = 1'b1;
                  retire = 1'b1;
               end else if (timer == TIMEOUT_LAST) begin
                  next_state = S_FAULT;
               end
            end
            S_HALT: begin
               halted = 1'b1;
            end
            S_FAULT: begin
               halted = 1'b1;
               fault  = 1'b1;
            end
            default: begin
               next_state = S_IDLE;
            end
         endcase
         // A single-stepped instruction always returns to IDLE, even if run rose meanwhile.
         if (retire) begin
            count_retire = 1'b1;
            next_state   = (run && !step_latch) ? S_FETCH : S_IDLE;
         end
      end
   end

   // State register and single-step latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         step_latch <= 1'b0;
      end else begin
         state <= next_state;
         if (step_set) begin
            step_latch <= 1'b1;
         end else if (retire) begin
            step_latch <= 1'b0;
         end
      end
   end

   // Multiply timeout counter: cleared at mul_start, counts every MUL_WAIT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer <= '0;
      end else if (timer_clear) begin
         timer <= '0;
      end else if (state == S_MUL_WAIT) begin
         timer <= timer + 8'd1;
      end
   end

   // Retired-instruction counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= '0;
      end else if (count_retire && (retired != {count_width{1'b1}})) begin
         retired <= retired + 1'b1;
      end
   end

endmodule
